// File: rtl/vram_scanout.sv
// Dual-port 128x64x2-bit video RAM with a VGA-class raster scan-out (integer upscale, vertical letterbox).
// Latency: CPU read data 1 clk after the address; raster counter state reaches sync/video/pixel pins after 2 clks.
// Backpressure: none; the raster free-runs and the CPU port accepts one read or write every clock.
module vram_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SCALE    = 5,
    parameter int V_OFFSET = (V_ACTIVE - 64 * SCALE) / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] vram_hpos,
    input  logic [5:0] vram_vpos,
    input  logic [1:0] vram_pixeli,
    input  logic       vram_we,
    output logic [1:0] vram_pixelo,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [1:0] pixel,
    output logic       frame_start
);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] BAND_BEG = 10'(V_OFFSET);
    localparam logic [9:0] BAND_END = 10'(V_OFFSET + 64 * SCALE);
    localparam logic [2:0] S_LAST   = 3'(SCALE - 1);

    // Stage 0: raster counters and scaled framebuffer coordinates
    logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [2:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d;
    logic [6:0] fb_x_q, fb_x_d;
    logic [5:0] fb_y_q, fb_y_d;
    logic       h_wrap, v_wrap;
    logic       vis0, band0, hs0, vs0, fs0;

    // Stage 1: RAM read data plus flags delayed to match
    logic [1:0] rd1_q;
    logic       vis1_q, band1_q, hs1_q, vs1_q, fs1_q;

    // Stage 2: pin registers
    logic [1:0] pixel_q, pixo_q;
    logic       hsync_q, vsync_q, video_on_q, frame_start_q;

    logic [1:0]  mem [0:8191];
    logic [12:0] a_addr, b_addr;

    assign a_addr = {vram_vpos, vram_hpos};
    assign b_addr = {fb_y_q, fb_x_q};

    assign h_wrap = (h_cnt_q == H_LAST);
    assign v_wrap = (v_cnt_q == V_LAST);
    assign vis0   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign band0  = (v_cnt_q >= BAND_BEG) && (v_cnt_q < BAND_END);
    assign hs0    = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vs0    = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    assign fs0    = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

    // Next raster position; sub counters replace a divide-by-SCALE
    always_comb begin
        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
        end

        sub_x_d = sub_x_q + 3'd1;
        fb_x_d  = fb_x_q;
        if (h_wrap) begin
            sub_x_d = 3'd0;
            fb_x_d  = 7'd0;
        end else if (sub_x_q == S_LAST) begin
            sub_x_d = 3'd0;
            fb_x_d  = fb_x_q + 7'd1;
        end

        // Row coordinates restart on entry to the image band, then step once per band line
        sub_y_d = sub_y_q;
        fb_y_d  = fb_y_q;
        if (h_wrap) begin
            if (v_cnt_d == BAND_BEG) begin
                sub_y_d = 3'd0;
                fb_y_d  = 6'd0;
            end else if (band0) begin
                if (sub_y_q == S_LAST) begin
                    sub_y_d = 3'd0;
                    fb_y_d  = fb_y_q + 6'd1;
                end else begin
                    sub_y_d = sub_y_q + 3'd1;
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            sub_x_q <= '0;
            sub_y_q <= '0;
            fb_x_q  <= '0;
            fb_y_q  <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            sub_x_q <= sub_x_d;
            sub_y_q <= sub_y_d;
            fb_x_q  <= fb_x_d;
            fb_y_q  <= fb_y_d;
        end
    end

    // CPU write port; unreset so the framebuffer survives a reset
    always_ff @(posedge clk) begin
        if (vram_we) begin
            mem[a_addr] <= vram_pixeli;
        end
    end

    // Scan read; a same-cycle CPU write to this address is seen one read later
    always_ff @(posedge clk) begin
        rd1_q <= mem[b_addr];
    end

    // CPU read register, returns pre-write data on an address collision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixo_q <= '0;
        end else begin
            pixo_q <= mem[a_addr];
        end
    end

    // Stage 1 flags, aligned with the RAM read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vis1_q  <= 1'b0;
            band1_q <= 1'b0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            fs1_q   <= 1'b0;
        end else begin
            vis1_q  <= vis0;
            band1_q <= band0;
            hs1_q   <= hs0;
            vs1_q   <= vs0;
            fs1_q   <= fs0;
        end
    end

    // Stage 2 pin registers; letterbox and blanking force the pixel to 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            pixel_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= ~hs1_q;
            vsync_q       <= ~vs1_q;
            video_on_q    <= vis1_q;
            pixel_q       <= (vis1_q && band1_q) ? rd1_q : 2'd0;
            frame_start_q <= fs1_q;
        end
    end

    assign vram_pixelo = pixo_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel       = pixel_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout on a shrunken raster (scale 2) so whole frames fit in a short run.
// Reference: pixel at screen (x,y) is fb[(y-offset)/scale][x/scale] inside the band, else 0.
// Covers reset, CPU port table, random CPU traffic, scan/write collision, mid-frame reset.
module tb_vram_scanout;
    localparam int S     = 2;
    localparam int HA    = 256;
    localparam int HFP   = 4;
    localparam int HSY   = 8;
    localparam int HBP   = 4;
    localparam int VA    = 136;
    localparam int VFP   = 2;
    localparam int VSY   = 2;
    localparam int VBP   = 3;
    localparam int HT    = HA + HFP + HSY + HBP;
    localparam int VT    = VA + VFP + VSY + VBP;
    localparam int VO    = (VA - 64 * S) / 2;
    localparam int FRAME = HT * VT;
    // Collision target: screen (40,44) -> framebuffer (x=20, y=20)
    localparam int T_COL = 44 * HT + 40;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] vram_hpos;
    logic [5:0] vram_vpos;
    logic [1:0] vram_pixeli;
    logic       vram_we;
    logic [1:0] vram_pixelo;
    logic       hsync, vsync, video_on, frame_start;
    logic [1:0] pixel;

    vram_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SCALE(S)
    ) dut (
        .clk(clk), .reset(reset),
        .vram_hpos(vram_hpos), .vram_vpos(vram_vpos), .vram_pixeli(vram_pixeli),
        .vram_we(vram_we), .vram_pixelo(vram_pixelo),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .pixel(pixel),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mdl [8192];      // reference framebuffer, -1 = never written
    int cyc;             // clock edges since reset release
    bit in_rst;
    bit run2;
    int scan_prev;       // framebuffer value the scan fetched on the previous edge
    int last_fs, fs_seen;
    int hs_lo, vs_lo, von_hi;

    typedef struct {
        bit we;
        int hp;
        int vp;
        int d;
        int exp_pixo;
    } pa_vec_t;
    pa_vec_t tbl [10];

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endfunction

    // Colour a raster index should show, before the output pipeline
    function automatic int scan_fetch(int t);
        int h, v;
        h = t % HT;
        v = (t / HT) % VT;
        if (h < HA && v < VA && v >= VO && v < VO + 64 * S)
            return mdl[((v - VO) / S) * 128 + h / S];
        return 0;
    endfunction

    function automatic int init_val(int a);
        if (a == 0) return 3;
        if (a == 8191) return 2;
        if (a == 20 * 128 + 20) return 1;
        return 0;
    endfunction

    task automatic step(input bit we, input int hp, input int vp, input int d);
        int a, exp_pixo, exp_pix, t, h, v;
        vram_we     = we;
        vram_hpos   = 7'(hp);
        vram_vpos   = 6'(vp);
        vram_pixeli = 2'(d);
        @(posedge clk);
        a        = vp * 128 + hp;
        exp_pixo = in_rst ? 0 : mdl[a];
        exp_pix  = 0;
        if (!in_rst) begin
            cyc++;
            exp_pix   = scan_prev;
            scan_prev = scan_fetch(cyc - 1);
        end
        if (we) mdl[a] = d;
        #1;
        if (exp_pixo >= 0) chk("pixelo", int'(vram_pixelo), exp_pixo);
        if (in_rst || cyc < 2) begin
            chk("idle_outs", int'({hsync, vsync, video_on, pixel, frame_start}), 48);
        end else begin
            t = cyc - 2;
            h = t % HT;
            v = (t / HT) % VT;
            chk("hsync", int'(hsync), int'(!(h >= HA + HFP && h < HA + HFP + HSY)));
            chk("vsync", int'(vsync), int'(!(v >= VA + VFP && v < VA + VFP + VSY)));
            chk("video_on", int'(video_on), int'(h < HA && v < VA));
            chk("frame_start", int'(frame_start), int'(t % FRAME == 0));
            if (exp_pix >= 0) chk("pixel", int'(pixel), exp_pix);
            if (cyc == 2) chk("fs_first", int'(frame_start), 1);
            if (cyc == 3) chk("fs_one_clk", int'(frame_start), 0);
            if (frame_start) begin
                if (fs_seen > 0) chk("fs_period", cyc - last_fs, FRAME);
                fs_seen++;
                last_fs = cyc;
            end
            if (!run2 && t < FRAME) begin
                hs_lo  += int'(!hsync);
                vs_lo  += int'(!vsync);
                von_hi += int'(video_on);
                if (t == FRAME - 1) begin
                    chk("hsync_low_clks", hs_lo, HSY * VT);
                    chk("vsync_low_clks", vs_lo, VSY * HT);
                    chk("video_on_clks", von_hi, HA * VA);
                end
            end
            if (!run2) begin
                if (t == T_COL)             chk("collide_old", int'(pixel), 1);
                if (t == T_COL + 1)         chk("collide_next_col", int'(pixel), 2);
                if (t == T_COL + HT)        chk("collide_next_line", int'(pixel), 2);
                if (t == FRAME + T_COL)     chk("collide_next_frame", int'(pixel), 2);
                if (t == 131 * HT + 254)    chk("last_fb_pixel", int'(pixel), 2);
                if (t == 131 * HT + 253)    chk("before_last_fb", int'(pixel), 0);
                if (t == (VO - 1) * HT)     chk("letterbox_top", int'(pixel), 0);
            end else begin
                if (t == VO * HT)           chk("post_rst_origin", int'(pixel), 3);
                if (t == VO * HT + 2)       chk("post_rst_origin_r", int'(pixel), 0);
                if (t == (VO + 1) * HT + 1) chk("post_rst_origin_d", int'(pixel), 3);
                if (t == T_COL)             chk("post_rst_collide", int'(pixel), 2);
            end
        end
    endtask

    initial begin
        int vp;
        tbl[0] = '{1'b1, 10, 5, 1, 0};
        tbl[1] = '{1'b0, 10, 5, 0, 1};
        tbl[2] = '{1'b1, 10, 5, 2, 1};
        tbl[3] = '{1'b0, 10, 5, 0, 2};
        tbl[4] = '{1'b0, 0, 0, 0, 3};
        tbl[5] = '{1'b0, 127, 63, 0, 2};
        tbl[6] = '{1'b1, 127, 63, 2, 2};
        tbl[7] = '{1'b1, 11, 5, 3, 0};
        tbl[8] = '{1'b0, 11, 5, 0, 3};
        tbl[9] = '{1'b0, 20, 20, 0, 1};

        for (int i = 0; i < 8192; i++) mdl[i] = -1;
        reset = 1'b1; in_rst = 1'b1; run2 = 1'b0;
        cyc = 0; scan_prev = 0; last_fs = 0; fs_seen = 0;
        hs_lo = 0; vs_lo = 0; von_hi = 0;
        vram_we = 1'b0; vram_hpos = '0; vram_vpos = '0; vram_pixeli = '0;

        repeat (3) step(1'b0, 0, 0, 0);
        reset = 1'b0; in_rst = 1'b0;

        // CPU clear pass with the reference pattern
        for (int a = 0; a < 8192; a++) step(1'b1, a % 128, a / 128, init_val(a));

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].we, tbl[i].hp, tbl[i].vp, tbl[i].d);
            chk($sformatf("tbl%0d_pixelo", i), int'(vram_pixelo), tbl[i].exp_pixo);
        end

        // Random CPU traffic (rows 0, 20, 63 kept intact) across one full frame
        while (cyc < FRAME + 50 * HT + 2) begin
            if (cyc == T_COL) begin
                step(1'b1, 20, 20, 2);
            end else begin
                vp = $urandom_range(1, 62);
                if (vp == 20) vp = 21;
                step($urandom_range(0, 3) == 0, $urandom_range(0, 127), vp, $urandom_range(0, 3));
            end
        end
        chk("fs_count", fs_seen, 2);

        // Mid-frame asynchronous reset
        reset = 1'b1;
        #2;
        chk("arst_hsync", int'(hsync), 1);
        chk("arst_vsync", int'(vsync), 1);
        chk("arst_video_on", int'(video_on), 0);
        chk("arst_pixel", int'(pixel), 0);
        chk("arst_frame_start", int'(frame_start), 0);
        chk("arst_pixelo", int'(vram_pixelo), 0);
        in_rst = 1'b1;
        repeat (3) step(1'b0, 5, 5, 0);
        reset = 1'b0; in_rst = 1'b0; run2 = 1'b1;
        cyc = 0; scan_prev = 0; fs_seen = 0;
        while (cyc < 50 * HT + 2) step(1'b0, $urandom_range(0, 127), $urandom_range(0, 63), 0);
        chk("fs_count_run2", fs_seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
